// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizing helpers and types for the register file slice
package regfile_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int MAX_REGS  = 256;

   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

   typedef logic [idx_width(NREGS_DEF)-1:0] reg_idx_t;

   // Callers zero-extend their busy vector to MAX_REGS bits.
   function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < MAX_REGS; i++) begin
         cnt = cnt + {31'b0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/regfile_sb_bypass_scoreboard.sv
// rtl/regfile_sb_bypass_scoreboard.sv - pending-write busy bits, claim acceptance and busy count
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int IDXW     = idx_width(NREGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NRD-1:0][IDXW-1:0] rd_idx,
   output logic [NRD-1:0]           rd_busy,
   input  logic                     wr_en,
   input  logic [IDXW-1:0]          wr_idx,
   input  logic                     alloc_en,
   input  logic [IDXW-1:0]          alloc_idx,
   output logic                     alloc_ok,
   input  logic                     flush,
   output logic [IDXW:0]            busy_cnt
);

   logic [NREGS-1:0]    busy_q, busy_d;
   logic [IDXW:0]       busy_cnt_q, busy_cnt_d;
   logic [MAX_REGS-1:0] busy_ext;
   logic                alloc_zero;

   assign alloc_zero = (ZERO_REG != 0) && (alloc_idx == '0);
   // A writeback landing this cycle frees the entry for an immediate re-claim.
   assign alloc_ok = alloc_en && !flush &&
                     (!busy_q[alloc_idx] || (wr_en && wr_idx == alloc_idx));

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rd_busy[p] = busy_q[rd_idx[p]] && !(wr_en && wr_idx == rd_idx[p]);
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (reset || flush) begin
         busy_d = '0;
      end else begin
         if (wr_en) busy_d[wr_idx] = 1'b0;
         if (alloc_ok && !alloc_zero) busy_d[alloc_idx] = 1'b1;
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_comb begin
      busy_ext = '0;
      busy_ext[NREGS-1:0] = busy_d;
      busy_cnt_d = (IDXW+1)'(popcount(busy_ext));
   end

   always_ff @(posedge clk) begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
   end

   assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb_bypass.sv
// rtl/regfile_sb_bypass.sv - register file with write-through bypass and pending-write scoreboard
module regfile_sb_bypass
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NRD-1:0][idx_width(NREGS)-1:0] rd_idx,
   output logic [NRD-1:0][XLEN-1:0]            rd_data,
   output logic [NRD-1:0]                      rd_busy,
   input  logic                                wr_en,
   input  logic [idx_width(NREGS)-1:0]         wr_idx,
   input  logic [XLEN-1:0]                     wr_data,
   input  logic                                alloc_en,
   input  logic [idx_width(NREGS)-1:0]         alloc_idx,
   output logic                                alloc_ok,
   input  logic                                flush,
   output logic [idx_width(NREGS):0]           busy_cnt
);

   localparam int IDXW = idx_width(NREGS);

   logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
   logic                       wr_zero;

   assign wr_zero = (ZERO_REG != 0) && (wr_idx == '0);

   always_comb begin
      regs_d = regs_q;
      if (reset) begin
         regs_d = '0;
      end else if (wr_en && !wr_zero) begin
         regs_d[wr_idx] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   // Bypass first, then the hardwired-zero override so x0 never forwards.
   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rd_data[p] = regs_q[rd_idx[p]];
         if (wr_en && wr_idx == rd_idx[p]) rd_data[p] = wr_data;
         if ((ZERO_REG != 0) && (rd_idx[p] == '0)) rd_data[p] = '0;
      end
   end

   regfile_scoreboard #(
      .NREGS   (NREGS),
      .NRD     (NRD),
      .ZERO_REG(ZERO_REG),
      .IDXW    (IDXW)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (rd_idx),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .alloc_en (alloc_en),
      .alloc_idx(alloc_idx),
      .alloc_ok (alloc_ok),
      .flush    (flush),
      .busy_cnt (busy_cnt)
   );

endmodule
